// File: rtl/tms4464_responder.sv
// tms4464_responder: 64K x 4 TMS4464 DRAM responder with sampled strobes and refresh counting.
// Define TMS4464_RESP_TIMING_CHECK_EN to enable the tRCD/tRAS/tRP/CAS-while-RAS-high checker.
module tms4464_responder #(
  parameter int T_RCD_MIN = 3,
  parameter int T_RAS_MIN = 10,
  parameter int T_RP_MIN  = 6
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [7:0]  ram_addr,
  inout  wire  [3:0]  ram_dq,
  input  logic        ram_ras_,
  input  logic        ram_cas_,
  input  logic        ram_we_,
  input  logic        ram_oe_,
  output logic        timing_error,
  output logic [2:0]  error_code,
  output logic [15:0] refresh_count
);
  typedef enum logic [1:0] {IDLE, ROW_OPEN, COL_ACTIVE, PRECHARGE} state_t;
  localparam logic [3:0] RP = 4'(T_RP_MIN);
  state_t      state_q;
  logic        ras_p_q, cas_p_q, seen_q, read_q, drive_q;
  logic [7:0]  row_q, col_q;
  logic [3:0]  pre_q;
  logic [15:0] refresh_q;
  logic [3:0]  mem [65536];
  logic        ras_fall, ras_rise, cas_fall, cas_rise, open_row, access, read_d;
  assign ras_fall = ras_p_q & ~ram_ras_;
  assign ras_rise = ~ras_p_q & ram_ras_;
  assign cas_fall = cas_p_q & ~ram_cas_;
  assign cas_rise = ~cas_p_q & ram_cas_;
  assign open_row = state_q == ROW_OPEN || state_q == COL_ACTIVE;
  // a RAS rise sampled together with a CAS fall closes the row without an access
  assign access   = cas_fall & (state_q == ROW_OPEN) & ~ras_rise;
  assign read_d   = access ? ram_we_ : read_q & open_row & ~ram_ras_ & ~ram_cas_;
  assign ram_dq   = drive_q ? mem[{row_q, col_q}] : 4'bz;
  assign refresh_count = refresh_q;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q   <= IDLE;
      ras_p_q   <= 1'b0;
      cas_p_q   <= 1'b0;
      seen_q    <= 1'b0;
      read_q    <= 1'b0;
      drive_q   <= 1'b0;
      row_q     <= 8'd0;
      col_q     <= 8'd0;
      pre_q     <= 4'd0;
      refresh_q <= 16'd0;
    end else begin
      ras_p_q <= ram_ras_;
      cas_p_q <= ram_cas_;
      read_q  <= read_d;
      drive_q <= read_d & ~ram_oe_;
      if (!open_row && ras_fall) begin
        state_q <= ROW_OPEN;
        row_q   <= ram_addr;
        seen_q  <= 1'b0;
      end else if (open_row && ras_rise) begin
        state_q <= PRECHARGE;
        pre_q   <= 4'd1;
        if (!seen_q) refresh_q <= refresh_q + 16'd1;
      end else if (access) begin
        state_q <= COL_ACTIVE;
        col_q   <= ram_addr;
        seen_q  <= 1'b1;
      end else if (state_q == COL_ACTIVE && cas_rise) begin
        state_q <= ROW_OPEN;
      end else if (state_q == PRECHARGE) begin
        if (pre_q >= RP) state_q <= IDLE;
        else pre_q <= pre_q + 4'd1;
      end
    end
  end
  // storage is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk) begin
    if (access && !ram_we_) mem[{row_q, ram_addr}] <= ram_dq;
  end
`ifdef TMS4464_RESP_TIMING_CHECK_EN
  localparam logic [3:0] RCD     = 4'(T_RCD_MIN);
  localparam logic [3:0] RAS_MIN = 4'(T_RAS_MIN);
  logic [3:0] ras_cnt_q;
  logic [2:0] code_q, code_d;
  always_comb
    code_d = code_q != 3'd0 ? code_q :
             (cas_fall && !ram_ras_ && (ras_fall || ras_cnt_q < RCD)) ? 3'd1 :
             (open_row && ras_rise && ras_cnt_q < RAS_MIN) ? 3'd2 :
             (state_q == PRECHARGE && ras_fall && pre_q < RP) ? 3'd3 :
             (cas_fall && ram_ras_) ? 3'd4 : 3'd0;
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ras_cnt_q <= 4'd0;
      code_q    <= 3'd0;
    end else begin
      code_q    <= code_d;
      ras_cnt_q <= ras_fall ? 4'd1 : (!ram_ras_ && ras_cnt_q != 4'hF) ? ras_cnt_q + 4'd1 : ras_cnt_q;
    end
  end
  assign timing_error = code_q != 3'd0;
  assign error_code   = code_q;
`else
  assign timing_error = 1'b0;
  assign error_code   = 3'd0;
`endif
endmodule

// File: tb/tb_tms4464_responder.sv
// tb_tms4464_responder: randomized scoreboard bench for tms4464_responder against an event-timestamp model.
module tb_tms4464_responder;
  localparam int T_RCD = 3, T_RAS = 10, T_RP = 6;
  logic        clk = 1'b0, reset_ = 1'b0;
  logic        ras = 1'b1, cas = 1'b1, we = 1'b1, oe = 1'b1, tb_drv = 1'b0;
  logic [7:0]  addr = 8'd0;
  logic [3:0]  tb_dq = 4'd0;
  wire  [3:0]  ram_dq;
  logic        timing_error;
  logic [2:0]  error_code;
  logic [15:0] refresh_count;
  assign ram_dq = tb_drv ? tb_dq : 4'bz;
  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (ram_dq[g]);
  end
  always #5 clk = ~clk;

  tms4464_responder dut (
    .clk(clk), .reset_(reset_), .ram_addr(addr), .ram_dq(ram_dq),
    .ram_ras_(ras), .ram_cas_(cas), .ram_we_(we), .ram_oe_(oe),
    .timing_error(timing_error), .error_code(error_code), .refresh_count(refresh_count)
  );

  typedef struct { logic [3:0] dq; logic [15:0] rc; logic te; logic [2:0] ec; } exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;
  event probe;

  // Reference model: row-open period tracked by fall/rise timestamps in cycles
  int n = 0, tf, tr;
  bit pr, pc, open, seen, rd_on, drv;
  logic [7:0] row;
  logic [15:0] ref_cnt;
  logic [2:0] code;
  logic [3:0] rdat;
  logic [3:0] mem [int];
  logic [15:0] wl[$];

  function automatic void mreset();
    open = 0; seen = 0; rd_on = 0; drv = 0; pr = 0; pc = 0;
    row = 8'd0; ref_cnt = 16'd0; code = 3'd0; rdat = 4'd0; tf = n; tr = -100;
  endfunction

  function automatic void mstep();
    bit rf, rr, cf, acc;
    logic [2:0] v;
    n++;
    if (!reset_) begin
      mreset();
      return;
    end
    rf = pr && !ras; rr = !pr && ras; cf = pc && !cas; acc = 0;
    v = 3'd0;
    if (cf && !ras && (rf || n - tf < T_RCD)) v = 3'd1;
    else if (open && rr && n - tf < T_RAS) v = 3'd2;
    else if (!open && rf && n - tr < T_RP) v = 3'd3;
    else if (cf && ras) v = 3'd4;
    if (code == 3'd0) code = v;
    if (!open && rf) begin
      open = 1; row = addr; tf = n; seen = 0;
    end else if (open && rr) begin
      open = 0; tr = n;
      if (!seen) ref_cnt++;
    end else if (open && cf) begin
      seen = 1; acc = 1;
      if (!we) mem[{16'd0, row, addr}] = tb_dq;
      else rdat = mem[{16'd0, row, addr}];
    end
    rd_on = acc ? we : rd_on && open && !ras && !cas;
    drv = rd_on && !oe;
    pr = ras; pc = cas;
  endfunction

  function automatic void push_exp();
    exp_t e;
    logic [2:0] c;
`ifdef TMS4464_RESP_TIMING_CHECK_EN
    c = code;
`else
    c = 3'd0;
`endif
    e.dq = drv ? rdat : tb_drv ? tb_dq : 4'hF;
    e.rc = ref_cnt;
    e.ec = c;
    e.te = c != 3'd0;
    sb.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, n, act, exp);
  endtask

  initial forever begin
    @(negedge clk or probe);
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("dq", {12'd0, ram_dq}, {12'd0, e.dq});
      chk("refresh_count", refresh_count, e.rc);
      chk("timing_error", {15'd0, timing_error}, {15'd0, e.te});
      chk("error_code", {13'd0, error_code}, {13'd0, e.ec});
    end
  end

  task automatic cyc(input logic r, c, w, o, input logic [7:0] a, input logic d, input logic [3:0] v);
    ras = r; cas = c; we = w; oe = o; addr = a; tb_drv = d; tb_dq = v;
    @(posedge clk);
    mstep();
    push_exp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    #1;
    mreset();
    push_exp();
    ->probe;
  endtask

  // one RAS period: CAS window [rcd, rcd+clen), RAS rises at rlen, then pre cycles high
  task automatic op(input logic [7:0] r, c, input logic w, input logic [3:0] v,
                    input int rcd, clen, rlen, pre, input bit oe_rand);
    for (int t = 0; t < rlen + pre; t++) begin
      bit cw;
      logic o;
      cw = t >= rcd && t < rcd + clen;
      o = (cw && w) ? (oe_rand ? ($urandom % 4 == 0) : 1'b0) : 1'b1;
      cyc(t >= rlen, !cw, cw ? w : 1'b1, o, t < rcd ? r : c, cw && !w, v);
    end
  endtask

  task automatic wr(input logic [7:0] r, c, input logic [3:0] v);
    op(r, c, 1'b0, v, 4, 2, 12, 8, 1'b0);
    wl.push_back({r, c});
  endtask

  initial begin
    mreset();
    repeat (3) cyc(1, 1, 1, 1, 8'd0, 0, 4'd0);
    reset_ = 1'b1;
    repeat (2) cyc(1, 1, 1, 1, 8'd0, 0, 4'd0);
    wr(8'h64, 8'h00, 4'hA);
    op(8'h64, 8'h00, 1'b1, 4'd0, 4, 2, 12, 8, 1'b0);
    repeat (3) op(8'h20, 8'h00, 1'b1, 4'd0, 4, 0, 12, 8, 1'b0);
    op(8'h64, 8'h00, 1'b1, 4'd0, 2, 2, 12, 8, 1'b0);
    op(8'h33, 8'h00, 1'b1, 4'd0, 4, 0, 8, 3, 1'b0);
    op(8'h33, 8'h00, 1'b1, 4'd0, 4, 0, 12, 8, 1'b0);
    wr(8'h40, 8'h10, 4'h3);
    wr(8'h40, 8'h11, 4'h5);
    repeat (4) cyc(0, 1, 1, 1, 8'h40, 0, 4'd0);
    repeat (2) cyc(0, 0, 1, 0, 8'h10, 0, 4'd0);
    cyc(0, 1, 1, 1, 8'h10, 0, 4'd0);
    repeat (2) cyc(0, 0, 1, 0, 8'h11, 0, 4'd0);
    do_reset();
    repeat (2) cyc(0, 0, 1, 0, 8'h11, 0, 4'd0);
    reset_ = 1'b1;
    repeat (3) cyc(0, 0, 1, 0, 8'h11, 0, 4'd0);
    repeat (8) cyc(1, 1, 1, 1, 8'h00, 0, 4'd0);
    op(8'h40, 8'h10, 1'b1, 4'd0, 4, 2, 12, 8, 1'b0);
    op(8'h40, 8'h11, 1'b1, 4'd0, 4, 2, 12, 8, 1'b0);
    repeat (40) begin
      int kind, rcd, clen, rlen, pre;
      logic [15:0] a;
      kind = $urandom % 4;
      rcd  = 2 + $urandom % 5;
      clen = 1 + $urandom % 3;
      rlen = 8 + $urandom % 7;
      if (rlen < rcd + clen + 1) rlen = rcd + clen + 1;
      pre  = 3 + $urandom % 7;
      if (kind == 0 || wl.size() == 0) begin
        a = 16'($urandom);
        op(a[15:8], a[7:0], 1'b0, 4'($urandom_range(0, 14)), rcd, clen, rlen, pre, 1'b0);
        wl.push_back(a);
      end else if (kind == 1) begin
        op(8'($urandom), 8'd0, 1'b1, 4'd0, rcd, 0, rlen, pre, 1'b0);
      end else begin
        a = wl[$urandom_range(0, wl.size() - 1)];
        op(a[15:8], a[7:0], 1'b1, 4'd0, rcd, clen, rlen, pre, 1'b1);
      end
    end
    repeat (2) cyc(1, 1, 1, 1, 8'd0, 0, 4'd0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not reach summary, got timeout expected finish");
    $fatal(1);
  end
endmodule
